gpio_padmux: RTL and testbench
==============================

# gpio_padmux

Parametrised pad-control and pin-multiplexing block between `chip_core` peripherals and the pad ring. Each bidir pad is owned either by a GPIO register or by one of up to three alternate peripheral functions. The block drives every pad control (OUT/OE/CS/SL/IE/PU/PD), synchronises pad inputs and raises a level interrupt on enabled rising/falling edges. Software access is through a simple single-cycle word-addressed register bus.

## Interface
Parameters:
- `NUM_BIDIR_PADS`, 18: bidir pads controlled; NB ≤ 32.
- `NUM_INPUT_PADS`, 7: input-only pads; NB+NI ≤ 32.
- `NUM_ALT`, 2: alternate functions per bidir pad, 1..3.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.

Ports:
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_valid`  in  1  register access strobe; always accepted, no backpressure.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  5  word address.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data.
- `bus_rvalid`  out  1  read data valid.
- `alt_out`  in  NUM_ALT*NB  alternate function output, function f pad i at bit f*NB+i.
- `alt_oe`  in  NUM_ALT*NB  alternate function output enable, same packing.
- `pad_sync`  out  NB  synchronised bidir input to peripherals.
- `bidir_in`  in  NB  raw pad input.
- `bidir_out`, `bidir_oe`, `bidir_cs`, `bidir_sl`, `bidir_ie`, `bidir_pu`, `bidir_pd`  out  NB  pad controls.
- `input_in`  in  NI  raw input pad value.
- `input_pu`, `input_pd`  out  NI  input pad pulls.
- `irq`  out  1  interrupt, level, active high.

## Operation
- Registers (addr: name, reset):
  - 0 OUT, 0.
  - 1 OE, 0.
  - 2 IN (RO, synced bidir).
  - 3 INPUT_IN (RO, synced inputs).
  - 4/5 FUNCSEL pads 0–15 / 16–31, 2 bits per pad, 0.
  - 6 PU, 0. 7 PD, 0. 8 CS, 0. 9 SL, 0. 10 IE, all-ones.
  - 11 INPUT_PU, 0. 12 INPUT_PD, 0.
  - 13 RISE_EN, 0. 14 FALL_EN, 0.
  - 15 PEND (W1C), 0.
  - 16 OUT_SET (WO). 17 OUT_CLR (WO).
  - Other addresses read 0; writes to them are ignored.
- Unimplemented bits read 0 and ignore writes. WO registers read 0.
- Event vector for RISE_EN/FALL_EN/PEND: bits [NB-1:0] are bidir pads, bits [NB+NI-1:NB] are input pads.
- FUNCSEL=0 selects GPIO: pad driven from OUT/OE.
- FUNCSEL=f, 1≤f≤NUM_ALT: pad driven from `alt_out`/`alt_oe` function f-1.
- FUNCSEL>NUM_ALT is treated as GPIO.
- CS/SL/IE/PU/PD always come from registers, never from peripherals.
- If PU and PD bits are both 1, PU wins and the PD output is forced 0. Same rule for input pads.
- OUT_SET: OUT |= wdata. OUT_CLR: OUT &= ~wdata.
- Edge detect: compare synced value with its one-cycle-delayed copy. Rising edge with RISE_EN set, or falling edge with FALL_EN set, sets the PEND bit.
- Edges on pads whose enable is clear are discarded, not latched.
- Clearing RISE_EN/FALL_EN does not clear PEND.
- A set and a W1C on the same bit in the same cycle: set wins.
- `irq` = OR of all PEND flops.
- `pad_sync` and IN are independent of FUNCSEL.

## Timing
- Writes take effect at the clock edge where `bus_valid & bus_we`. Pad outputs reflect the new value after that edge.
- Reads: `bus_rvalid` is high exactly one cycle after `bus_valid & !bus_we`. `bus_rdata` holds its value until the next read; it is 0 after reset.
- `bidir_out`/`bidir_oe` are registered: one cycle of latency from `alt_out`/`alt_oe` or register update.
- Synchroniser (SYNC_STAGES=2): pad change first sampled at edge k.
  - Visible on `pad_sync`/IN after edge k+1.
  - PEND set and `irq` high after edge k+2.
  - Each extra stage adds one cycle.
- Reset asserted, asynchronously and without waiting for `clk`:
  - `bidir_oe`, `bidir_out`, `bidir_cs`, `bidir_sl`, `bidir_pu`, `bidir_pd`, `input_pu`, `input_pd` = 0.
  - `bidir_ie` = all-ones.
  - `irq`, `bus_rvalid`, `bus_rdata`, `pad_sync` = 0.
  - Synchroniser and delay flops = 0.
  - Reset mid-access aborts the access; no `bus_rvalid` follows.
- First clock after reset release: a pad already at 1 causes a rising edge. It is ignored because RISE_EN resets to 0.

## Test plan
- Reset: assert `rst` with `clk` stopped → all outputs reach reset values immediately. Read addr 10 after release → 0x3FFFF (NB=18).
- GPIO and SET/CLR:
  - Write OE=0x00001, OUT=0x1 → pad0 `bidir_oe`=1, `bidir_out`=1 next cycle.
  - OUT_CLR 0x1 → `bidir_out`[0]=0.
  - OUT_SET 0x30 → OUT reads 0x31.
- Mux: FUNCSEL0=0x2 (pad0→func1, i.e. `alt_*` function index 1), `alt_out`[NB+0]=1, `alt_oe`[NB+0]=1 → `bidir_out[0]`=`bidir_oe[0]`=1 one cycle later. FUNCSEL0=0x3 with NUM_ALT=2 → GPIO values.
- Pull conflict: PU=PD=0x4 → `bidir_pu[2]`=1, `bidir_pd[2]`=0. Same check on INPUT_PU/PD.
- Interrupt latency: RISE_EN bit 18 (input pad 0); toggle `input_in[0]` 0→1 before edge k →
  - `irq`=1 after edge k+2; PEND reads 0x40000.
  - W1C 0x40000 → `irq`=0 next cycle.
  - A falling edge with FALL_EN=0 → no PEND.
- Set/clear collision: schedule the edge detect and a W1C of the same PEND bit in the same cycle → bit stays 1 and `irq` stays 1.

Source files
------------

// File: rtl/gpio_padmux.sv
// gpio_padmux: bidir/input pad control, alternate-function muxing,
// input synchronisation and edge-triggered level interrupt.
module gpio_padmux #(
   parameter int NUM_BIDIR_PADS = 18,
   parameter int NUM_INPUT_PADS = 7,
   parameter int NUM_ALT        = 2,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     bus_valid,
   input  logic                                     bus_we,
   input  logic [4:0]                               bus_addr,
   input  logic [31:0]                              bus_wdata,
   output logic [31:0]                              bus_rdata,
   output logic                                     bus_rvalid,
   input  logic [NUM_ALT*NUM_BIDIR_PADS-1:0]        alt_out,
   input  logic [NUM_ALT*NUM_BIDIR_PADS-1:0]        alt_oe,
   output logic [NUM_BIDIR_PADS-1:0]                pad_sync,
   input  logic [NUM_BIDIR_PADS-1:0]                bidir_in,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_out,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_oe,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_cs,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_sl,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_ie,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_pu,
   output logic [NUM_BIDIR_PADS-1:0]                bidir_pd,
   input  logic [NUM_INPUT_PADS-1:0]                input_in,
   output logic [NUM_INPUT_PADS-1:0]                input_pu,
   output logic [NUM_INPUT_PADS-1:0]                input_pd,
   output logic                                     irq
);

   localparam int NB = NUM_BIDIR_PADS;
   localparam int NI = NUM_INPUT_PADS;
   localparam int NE = NB + NI;
   localparam logic [31:0] B_MASK = 32'((64'd1 << NB) - 64'd1);
   localparam logic [31:0] I_MASK = 32'((64'd1 << NI) - 64'd1);
   localparam logic [63:0] F_MASK = 64'((128'd1 << (2 * NB)) - 128'd1);

   logic [31:0] out_q, oe_q, pu_q, pd_q, cs_q, sl_q, ie_q;
   logic [31:0] ipu_q, ipd_q, rise_q, fall_q, pend_q;
   logic [63:0] fs_q;

   logic [SYNC_STAGES-1:0][NE-1:0] sync_r;
   logic [NE-1:0] sync_v, prev_q, ev;
   logic [NB-1:0] mux_out, mux_oe;
   logic [31:0] rd_v, w1c;
   logic        wr, rd;

   assign wr = bus_valid & bus_we;
   assign rd = bus_valid & ~bus_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         oe_q   <= '0;
         pu_q   <= '0;
         pd_q   <= '0;
         cs_q   <= '0;
         sl_q   <= '0;
         ie_q   <= B_MASK;
         ipu_q  <= '0;
         ipd_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         fs_q   <= '0;
      end else if (wr) begin
         case (bus_addr)
            5'd0:  out_q  <= bus_wdata & B_MASK;
            5'd1:  oe_q   <= bus_wdata & B_MASK;
            5'd4:  fs_q[31:0]  <= bus_wdata & F_MASK[31:0];
            5'd5:  fs_q[63:32] <= bus_wdata & F_MASK[63:32];
            5'd6:  pu_q   <= bus_wdata & B_MASK;
            5'd7:  pd_q   <= bus_wdata & B_MASK;
            5'd8:  cs_q   <= bus_wdata & B_MASK;
            5'd9:  sl_q   <= bus_wdata & B_MASK;
            5'd10: ie_q   <= bus_wdata & B_MASK;
            5'd11: ipu_q  <= bus_wdata & I_MASK;
            5'd12: ipd_q  <= bus_wdata & I_MASK;
            5'd13: rise_q <= 32'(bus_wdata[NE-1:0]);
            5'd14: fall_q <= 32'(bus_wdata[NE-1:0]);
            5'd16: out_q  <= out_q | (bus_wdata & B_MASK);
            5'd17: out_q  <= out_q & ~bus_wdata;
            default: ;
         endcase
      end
   end

   // Input synchroniser plus one-cycle delayed copy for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
         prev_q <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], {input_in, bidir_in}};
         prev_q <= sync_v;
      end
   end

   assign sync_v = sync_r[SYNC_STAGES-1];
   assign ev = (sync_v & ~prev_q & rise_q[NE-1:0])
             | (~sync_v & prev_q & fall_q[NE-1:0]);
   assign w1c = (wr && bus_addr == 5'd15) ? bus_wdata : '0;

   // New events OR in after the clear so a same-cycle set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= (pend_q & ~w1c) | 32'(ev);
   end

   always_comb begin
      mux_out = out_q[NB-1:0];
      mux_oe  = oe_q[NB-1:0];
      for (int i = 0; i < NB; i++) begin
         for (int f = 0; f < NUM_ALT; f++) begin
            if (fs_q[2*i +: 2] == 2'(f + 1)) begin
               mux_out[i] = alt_out[f*NB + i];
               mux_oe[i]  = alt_oe[f*NB + i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bidir_out <= '0;
         bidir_oe  <= '0;
      end else begin
         bidir_out <= mux_out;
         bidir_oe  <= mux_oe;
      end
   end

   always_comb begin
      rd_v = '0;
      case (bus_addr)
         5'd0:  rd_v = out_q;
         5'd1:  rd_v = oe_q;
         5'd2:  rd_v = 32'(sync_v[NB-1:0]);
         5'd3:  rd_v = 32'(sync_v[NE-1:NB]);
         5'd4:  rd_v = fs_q[31:0];
         5'd5:  rd_v = fs_q[63:32];
         5'd6:  rd_v = pu_q;
         5'd7:  rd_v = pd_q;
         5'd8:  rd_v = cs_q;
         5'd9:  rd_v = sl_q;
         5'd10: rd_v = ie_q;
         5'd11: rd_v = ipu_q;
         5'd12: rd_v = ipd_q;
         5'd13: rd_v = rise_q;
         5'd14: rd_v = fall_q;
         5'd15: rd_v = pend_q;
         default: rd_v = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_rvalid <= 1'b0;
         bus_rdata  <= '0;
      end else begin
         bus_rvalid <= rd;
         if (rd) bus_rdata <= rd_v;
      end
   end

   assign pad_sync = sync_v[NB-1:0];
   assign bidir_cs = cs_q[NB-1:0];
   assign bidir_sl = sl_q[NB-1:0];
   assign bidir_ie = ie_q[NB-1:0];
   assign bidir_pu = pu_q[NB-1:0];
   assign bidir_pd = pd_q[NB-1:0] & ~pu_q[NB-1:0];
   assign input_pu = ipu_q[NI-1:0];
   assign input_pd = ipd_q[NI-1:0] & ~ipu_q[NI-1:0];
   assign irq      = |pend_q;

endmodule

// File: tb/tb_gpio_padmux.sv
// Scoreboard bench for gpio_padmux: bus reads are checked by a monitor,
// pad-level outputs are checked directly at falling clock edges.
module tb_gpio_padmux;

   localparam int NB = 18;
   localparam int NI = 7;
   localparam int NA = 2;

   logic              clk = 1'b0;
   logic              clk_run = 1'b0;
   logic              rst = 1'b0;
   logic              bus_valid = 1'b0;
   logic              bus_we = 1'b0;
   logic [4:0]        bus_addr = '0;
   logic [31:0]       bus_wdata = '0;
   logic [31:0]       bus_rdata;
   logic              bus_rvalid;
   logic [NA*NB-1:0]  alt_out = '0;
   logic [NA*NB-1:0]  alt_oe = '0;
   logic [NB-1:0]     pad_sync;
   logic [NB-1:0]     bidir_in = '0;
   logic [NB-1:0]     bidir_out, bidir_oe, bidir_cs, bidir_sl;
   logic [NB-1:0]     bidir_ie, bidir_pu, bidir_pd;
   logic [NI-1:0]     input_in = '0;
   logic [NI-1:0]     input_pu, input_pd;
   logic              irq;

   gpio_padmux #(
      .NUM_BIDIR_PADS(NB), .NUM_INPUT_PADS(NI),
      .NUM_ALT(NA), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst),
      .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
      .alt_out(alt_out), .alt_oe(alt_oe),
      .pad_sync(pad_sync), .bidir_in(bidir_in),
      .bidir_out(bidir_out), .bidir_oe(bidir_oe),
      .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
      .bidir_ie(bidir_ie), .bidir_pu(bidir_pu),
      .bidir_pd(bidir_pd), .input_in(input_in),
      .input_pu(input_pu), .input_pd(input_pd),
      .irq(irq)
   );

   initial forever begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every read response pops one expectation
   always @(negedge clk) begin
      if (!rst && bus_rvalid) begin
         if (q.size() == 0) begin
            chk("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, bus_rdata, e.exp);
         end
      end
   end

   // Callers are always positioned at a falling edge
   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      bus_valid = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = a;
      bus_wdata = d;
      @(negedge clk);
      bus_valid = 1'b0;
      bus_we    = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, input logic [31:0] e,
                         input string name);
      exp_t x;
      x.name = name;
      x.exp  = e;
      q.push_back(x);
      bus_valid = 1'b1;
      bus_we    = 1'b0;
      bus_addr  = a;
      @(negedge clk);
      bus_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Asynchronous reset with the clock stopped
      #3 rst = 1'b1;
      #1;
      chk("rst_oe", 32'(bidir_oe), 32'h0);
      chk("rst_out", 32'(bidir_out), 32'h0);
      chk("rst_ie", 32'(bidir_ie), 32'h3FFFF);
      chk("rst_pu_pd", 32'({bidir_pu, bidir_pd, bidir_cs, bidir_sl}), 32'h0);
      chk("rst_in_pulls", 32'({input_pu, input_pd}), 32'h0);
      chk("rst_irq_rv", 32'({irq, bus_rvalid}), 32'h0);
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_pad_sync", 32'(pad_sync), 32'h0);
      clk_run = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);

      bus_rd(5'd10, 32'h0003FFFF, "rd_ie");
      bus_rd(5'd0, 32'h0, "rd_out_rst");

      // GPIO drive and SET/CLR
      bus_wr(5'd1, 32'h1);
      bus_wr(5'd0, 32'h1);
      @(negedge clk);
      chk("gpio_oe0", 32'(bidir_oe), 32'h1);
      chk("gpio_out0", 32'(bidir_out), 32'h1);
      bus_wr(5'd16, 32'h30);
      bus_rd(5'd0, 32'h31, "out_set");
      bus_wr(5'd17, 32'h1);
      bus_rd(5'd0, 32'h30, "out_clr");
      chk("gpio_out_clr", 32'(bidir_out), 32'h30);
      bus_wr(5'd1, 32'h0);

      // Alternate-function mux
      alt_out[NB] = 1'b1;
      alt_oe[NB]  = 1'b1;
      alt_oe[0]   = 1'b1;
      bus_wr(5'd4, 32'h2);
      @(negedge clk);
      chk("mux_f1", 32'({bidir_out[0], bidir_oe[0], bidir_out[4]}), 32'h7);
      bus_wr(5'd4, 32'h1);
      @(negedge clk);
      chk("mux_f0", 32'({bidir_out[0], bidir_oe[0]}), 32'h1);
      bus_wr(5'd4, 32'h3);
      @(negedge clk);
      chk("mux_sel3_gpio", 32'({bidir_out[0], bidir_oe[0]}), 32'h0);
      bus_rd(5'd4, 32'h3, "rd_fs0");
      bus_wr(5'd5, 32'hFFFFFFFF);
      bus_rd(5'd5, 32'hF, "rd_fs1_mask");
      bus_wr(5'd5, 32'h0);
      bus_wr(5'd4, 32'h0);

      // Pull conflicts, CS/SL, unimplemented bits
      bus_wr(5'd6, 32'h4);
      bus_wr(5'd7, 32'hC);
      chk("pull_pu", 32'(bidir_pu), 32'h4);
      chk("pull_pd", 32'(bidir_pd), 32'h8);
      bus_wr(5'd11, 32'h4);
      bus_wr(5'd12, 32'h6);
      chk("in_pull", 32'({input_pu, input_pd}), 32'h202);
      bus_wr(5'd8, 32'h5);
      bus_wr(5'd9, 32'h20000);
      chk("cs_sl", 32'({bidir_cs[3:0], bidir_sl[17]}), 32'hB);
      bus_wr(5'd0, 32'hFFFFFFFF);
      bus_rd(5'd0, 32'h0003FFFF, "out_mask");
      bus_wr(5'd20, 32'h12345678);
      bus_rd(5'd20, 32'h0, "rd_unmapped");
      bus_rd(5'd16, 32'h0, "rd_wo_set");
      bus_wr(5'd0, 32'h0);

      // Synchroniser latency; edge on disabled pad is discarded
      bidir_in[3] = 1'b1;
      @(negedge clk);
      chk("sync_k", 32'(pad_sync[3]), 32'h0);
      @(negedge clk);
      chk("sync_k1", 32'(pad_sync[3]), 32'h1);
      bus_rd(5'd2, 32'h8, "rd_in");

      // Interrupt latency on input pad 0
      bus_wr(5'd13, 32'h40000);
      input_in[0] = 1'b1;
      @(negedge clk);
      chk("irq_k", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_k1", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_k2", 32'(irq), 32'h1);
      bus_rd(5'd15, 32'h40000, "pend_rise");
      bus_rd(5'd3, 32'h1, "rd_input_in");
      bus_wr(5'd15, 32'h40000);
      chk("irq_w1c", 32'(irq), 32'h0);
      input_in[0] = 1'b0;
      idle(4);
      chk("fall_disabled", 32'(irq), 32'h0);
      bus_rd(5'd15, 32'h0, "pend_none");

      // Clearing the enable keeps the pending flag
      bus_wr(5'd14, 32'h8);
      bidir_in[3] = 1'b0;
      idle(4);
      chk("fall_irq", 32'(irq), 32'h1);
      bus_wr(5'd14, 32'h0);
      bus_rd(5'd15, 32'h8, "pend_kept");
      bus_wr(5'd15, 32'h8);
      bus_rd(5'd15, 32'h0, "pend_w1c");

      // Set and W1C of the same bit on the same edge
      input_in[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_wr(5'd15, 32'h40000);
      chk("collide_irq", 32'(irq), 32'h1);
      @(negedge clk);
      chk("collide_irq_hold", 32'(irq), 32'h1);
      bus_rd(5'd15, 32'h40000, "collide_pend");

      // Reset in the middle of a read aborts it
      bus_valid = 1'b1;
      bus_we    = 1'b0;
      bus_addr  = 5'd15;
      #2 rst = 1'b1;
      @(negedge clk);
      bus_valid = 1'b0;
      chk("abort_rvalid", 32'(bus_rvalid), 32'h0);
      chk("abort_irq_ie", 32'({irq, bidir_ie}), 32'h3FFFF);
      rst = 1'b0;
      idle(3);
      chk("sb_empty", 32'(q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
